// File: rtl/fir2d_pkg.sv
// Shared definitions for the 2-D FIR coefficient path.
// Holds the default set geometry, the loader FSM state type and the
// coefficient sign-extension helper used when widening ROM words onto hwdata.
package fir2d_pkg;

  localparam int NUM_TAPS = 25;
  localparam int NUM_SETS = 4;
  localparam int COEFF_W  = 16;
  localparam int DATA_W   = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    XFER    = 2'd1,
    LAST    = 2'd2,
    WAIT_VS = 2'd3
  } load_state_t;

  function automatic logic [DATA_W-1:0] sign_extend(input logic [COEFF_W-1:0] c);
    return {{(DATA_W-COEFF_W){c[COEFF_W-1]}}, c};
  endfunction

endpackage

// File: rtl/coeff_load_sched.sv
// Coefficient load scheduler.
// Copies one coefficient set from the ROM into the bram2coeff shadow
// registers over a pipelined write port and holds off the frame sync until the
// whole set is written, then reports the commit.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start_i, set_sel_i  load request and set index
//   busy_o              high from start acceptance until commit
//   commit_o, err_o     single-cycle commit / bad-set pulses
//   rom_en_o, rom_addr_o, rom_data_i  ROM read port (data one cycle after enable)
//   haddr, hwrite       address phase of the write port
//   hwdata              data phase of the write port (sign-extended coefficient)
//   hready              slave ready, stalls address and data phases
//   vs_i, vs_o          raw and gated frame sync
module coeff_load_sched #(
  parameter int NUM_TAPS = fir2d_pkg::NUM_TAPS,
  parameter int NUM_SETS = fir2d_pkg::NUM_SETS,
  parameter int COEFF_W  = fir2d_pkg::COEFF_W,
  parameter int DATA_W   = fir2d_pkg::DATA_W,
  parameter int ADDR_W   = 32,
  parameter int ROM_AW   = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [1:0]        set_sel_i,
  output logic              busy_o,
  output logic              commit_o,
  output logic              err_o,
  output logic              rom_en_o,
  output logic [ROM_AW-1:0] rom_addr_o,
  input  logic [COEFF_W-1:0] rom_data_i,
  output logic [ADDR_W-1:0] haddr,
  output logic [DATA_W-1:0] hwdata,
  output logic              hwrite,
  input  logic              hready,
  input  logic              vs_i,
  output logic              vs_o
);

  fir2d_pkg::load_state_t state, state_next;

  logic [ADDR_W-1:0] idx;
  logic [ROM_AW-1:0] base;
  logic [DATA_W-1:0] hold;
  logic              data_first;
  logic              gate;
  logic              vs_q;
  logic              start_ok;
  logic              start_bad;
  logic              last_idx;
  logic              vs_rise;

  assign start_ok  = (state == fir2d_pkg::IDLE) && start_i && (int'(set_sel_i) < NUM_SETS);
  assign start_bad = (state == fir2d_pkg::IDLE) && start_i && (int'(set_sel_i) >= NUM_SETS);
  assign last_idx  = (idx == ADDR_W'(NUM_TAPS - 1));
  assign vs_rise   = vs_i & ~vs_q;

  assign haddr      = idx;
  assign rom_addr_o = base + idx[ROM_AW-1:0];
  // First data-phase cycle takes the ROM word directly; stalled cycles replay it.
  assign hwdata     = data_first ? fir2d_pkg::sign_extend(rom_data_i) : hold;
  assign vs_o       = vs_i & ~gate;

  always_ff @(posedge clk) begin
    if (rst) state <= fir2d_pkg::IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    hwrite     = 1'b0;
    rom_en_o   = 1'b0;
    case (state)
      fir2d_pkg::IDLE: begin
        if (start_ok) state_next = fir2d_pkg::XFER;
      end
      fir2d_pkg::XFER: begin
        hwrite   = 1'b1;
        rom_en_o = hready;
        if (hready && last_idx) state_next = fir2d_pkg::LAST;
      end
      fir2d_pkg::LAST: begin
        if (hready) state_next = fir2d_pkg::WAIT_VS;
      end
      fir2d_pkg::WAIT_VS: begin
        if (vs_rise) state_next = fir2d_pkg::IDLE;
      end
      default: state_next = fir2d_pkg::IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx        <= '0;
      base       <= '0;
      hold       <= '0;
      data_first <= 1'b0;
      gate       <= 1'b0;
      vs_q       <= 1'b0;
      busy_o     <= 1'b0;
      commit_o   <= 1'b0;
      err_o      <= 1'b0;
    end else begin
      commit_o   <= 1'b0;
      err_o      <= start_bad;
      vs_q       <= vs_i;
      data_first <= (state == fir2d_pkg::XFER) && hready;
      if (data_first) hold <= fir2d_pkg::sign_extend(rom_data_i);
      if (start_ok) begin
        base   <= ROM_AW'(set_sel_i) * ROM_AW'(NUM_TAPS);
        idx    <= '0;
        busy_o <= 1'b1;
        gate   <= 1'b1;
      end
      if ((state == fir2d_pkg::XFER) && hready && !last_idx) idx <= idx + 1'b1;
      if ((state == fir2d_pkg::LAST) && hready) gate <= 1'b0;
      if ((state == fir2d_pkg::WAIT_VS) && vs_rise) begin
        commit_o <= 1'b1;
        busy_o   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_coeff_load_sched.sv
// Self-checking bench for coeff_load_sched with a 3-set ROM.
module tb_coeff_load_sched;

  localparam int TAPS   = 25;
  localparam int SETS   = 3;
  localparam int ROM_AW = 7;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic              start_i;
  logic [1:0]        set_sel_i;
  logic              busy_o, commit_o, err_o, rom_en_o;
  logic [ROM_AW-1:0] rom_addr_o;
  logic [15:0]       rom_data_i;
  logic [31:0]       haddr, hwdata;
  logic              hwrite, hready, vs_i, vs_o;

  logic [15:0] rom [0:127];

  int n_cmp = 0;
  int n_bad = 0;

  coeff_load_sched #(.NUM_SETS(SETS)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .set_sel_i(set_sel_i),
    .busy_o(busy_o), .commit_o(commit_o), .err_o(err_o),
    .rom_en_o(rom_en_o), .rom_addr_o(rom_addr_o), .rom_data_i(rom_data_i),
    .haddr(haddr), .hwdata(hwdata), .hwrite(hwrite), .hready(hready),
    .vs_i(vs_i), .vs_o(vs_o)
  );

  // Synchronous ROM: data one cycle after the enable.
  always @(posedge clk) if (rom_en_o) rom_data_i <= rom[rom_addr_o];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] widen(input logic [15:0] c);
    int v;
    v = int'(signed'(c));
    return 32'(v);
  endfunction

  // pat: 0 -> k+10, 1 -> -k, 2 -> random
  // mode: 0 nominal, 1 stall at beat 7, 2 random hready, 3 early vs at cycle 10
  task automatic run_load(input int s, input int pat, input int mode);
    logic [31:0] exp_data [TAPS];
    int          addrs[$];
    logic [31:0] datas[$];
    int cyc, first_acc, last_acc, last_dat, stalls, vs_cyc;
    bit pend, done, saw_commit, saw_err;

    for (int k = 0; k < TAPS; k++) begin
      case (pat)
        0:       rom[s*TAPS+k] = 16'(k + 10);
        1:       rom[s*TAPS+k] = 16'(-k);
        default: rom[s*TAPS+k] = 16'($urandom);
      endcase
      exp_data[k] = widen(rom[s*TAPS+k]);
    end

    set_sel_i = 2'(s); start_i = 1'b1; hready = 1'b1; vs_i = 1'b0;
    @(negedge clk);
    check("c0_busy", busy_o, 0);
    step();
    start_i = 1'b0;
    first_acc = -1; last_acc = -1; last_dat = -1; stalls = 0;
    pend = 0; done = 0; saw_commit = 0; saw_err = 0;
    cyc = 1;
    while (!done && cyc < 400) begin
      start_i = (cyc == 5);
      if (cyc == 5) set_sel_i = 2'd3;
      case (mode)
        1: begin
          hready = !(hwrite && haddr == 32'd7 && stalls < 3);
          if (!hready) stalls++;
        end
        2:       hready = ($urandom_range(0, 3) != 0);
        default: hready = 1'b1;
      endcase
      vs_i = (mode == 3 && cyc == 10);
      @(negedge clk);
      if (cyc == 1) begin
        check("c1_busy", busy_o, 1);
        check("c1_haddr", haddr, 0);
        check("c1_hwrite", hwrite, 1);
      end
      if (vs_i) check("early_vs_o", vs_o, 0);
      if (commit_o) saw_commit = 1;
      if (err_o) saw_err = 1;
      if (mode == 1 && !hready) begin
        check("stall_haddr", haddr, 7);
        check("stall_hwdata", hwdata, exp_data[6]);
      end
      if (pend && hready) begin
        datas.push_back(hwdata);
        pend = 0;
        if (datas.size() == TAPS) begin
          last_dat = cyc;
          done = 1;
        end
      end
      if (hwrite && hready) begin
        check("rom_en", rom_en_o, 1);
        check("rom_addr", 32'(rom_addr_o), 32'(s*TAPS) + haddr);
        addrs.push_back(int'(haddr));
        pend = 1;
        if (first_acc < 0) first_acc = cyc;
        last_acc = cyc;
      end
      step();
      cyc++;
    end
    start_i = 1'b0;
    check("beats_done", datas.size(), TAPS);
    if (!done) return;

    check("n_addr", addrs.size(), TAPS);
    for (int k = 0; k < TAPS; k++) begin
      if (k < addrs.size()) check("addr_seq", addrs[k], k);
      check("data_seq", datas[k], exp_data[k]);
    end
    if (pat == 1) check("neg_one", datas[1], 32'hFFFF_FFFF);
    if (mode == 0 || mode == 3) begin
      check("first_acc_cyc", first_acc, 1);
      check("last_acc_cyc", last_acc, 25);
      check("last_dat_cyc", last_dat, 26);
    end
    check("no_commit_xfer", saw_commit, 0);
    check("no_err_busy", saw_err, 0);

    vs_cyc = (mode == 0) ? 40 : last_dat + 5;
    hready = 1'b1;
    while (cyc < vs_cyc) begin
      vs_i = 1'b0;
      @(negedge clk);
      check("wait_busy", busy_o, 1);
      check("wait_commit", commit_o, 0);
      check("wait_hwrite", hwrite, 0);
      step();
      cyc++;
    end
    vs_i = 1'b1;
    @(negedge clk);
    check("vs_pass", vs_o, 1);
    check("commit_early", commit_o, 0);
    step();
    vs_i = 1'b0;
    @(negedge clk);
    check("commit", commit_o, 1);
    check("busy_clear", busy_o, 0);
    step();
    @(negedge clk);
    check("commit_pulse", commit_o, 0);
    check("haddr_hold", haddr, TAPS - 1);
    check("hwdata_hold", hwdata, exp_data[TAPS-1]);
    step();
  endtask

  task automatic run_bad_set();
    set_sel_i = 2'd3; start_i = 1'b1; hready = 1'b1; vs_i = 1'b0;
    step();
    start_i = 1'b0;
    @(negedge clk);
    check("err_pulse", err_o, 1);
    check("err_busy", busy_o, 0);
    check("err_hwrite", hwrite, 0);
    step();
    @(negedge clk);
    check("err_clear", err_o, 0);
    check("err_hwrite2", hwrite, 0);
    step();
  endtask

  task automatic run_reset_abort(input int s);
    int n;
    for (int k = 0; k < TAPS; k++) rom[s*TAPS+k] = 16'($urandom);
    set_sel_i = 2'(s); start_i = 1'b1; hready = 1'b1; vs_i = 1'b0;
    step();
    start_i = 1'b0;
    n = 0;
    while (!(hwrite && haddr == 32'd12) && n < 100) begin
      step();
      n++;
    end
    check("reach_beat12", haddr, 12);
    rst = 1'b1; vs_i = 1'b1;
    step();
    @(negedge clk);
    check("rst_busy", busy_o, 0);
    check("rst_hwrite", hwrite, 0);
    check("rst_rom_en", rom_en_o, 0);
    check("rst_haddr", haddr, 0);
    check("rst_hwdata", hwdata, 0);
    check("rst_rom_addr", 32'(rom_addr_o), 0);
    check("rst_vs_o", vs_o, 1);
    step();
    rst = 1'b0; vs_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_rst_hwrite", hwrite, 0);
      check("post_rst_busy", busy_o, 0);
      step();
    end
  endtask

  initial begin
    for (int i = 0; i < 128; i++) rom[i] = 16'($urandom);
    rst = 1'b1; start_i = 1'b0; set_sel_i = 2'd0; hready = 1'b1; vs_i = 1'b0;
    step(); step();
    @(negedge clk);
    check("reset_busy", busy_o, 0);
    check("reset_commit", commit_o, 0);
    check("reset_err", err_o, 0);
    check("reset_rom_en", rom_en_o, 0);
    check("reset_hwrite", hwrite, 0);
    check("reset_haddr", haddr, 0);
    check("reset_hwdata", hwdata, 0);
    check("reset_rom_addr", 32'(rom_addr_o), 0);
    step();
    rst = 1'b0;
    step();

    run_load(0, 0, 0);
    run_load(2, 1, 0);
    run_load(1, 2, 1);
    run_load(0, 2, 3);
    run_bad_set();
    run_reset_abort(1);
    run_load(2, 2, 0);
    for (int t = 0; t < 4; t++) run_load(int'($urandom_range(0, SETS - 1)), 2, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/coeff_load_sched.md
Name: coeff_load_sched

Overview:
- Sequences a full 5x5 FIR coefficient set from a multi-set coefficient ROM into the bram2coeff shadow registers.
- Drives bram2coeff's haddr/hwdata/hwrite write port as a pipelined master: the address phase is followed by a data phase one cycle later.
- Gates the frame sync (vs) fed to bram2coeff so that a partially written set is never committed, then reports the commit.
- Sits between the host/register file and bram2coeff.

Parameters:
- NUM_TAPS, 25, coefficients per set; write addresses 0..NUM_TAPS-1.
- NUM_SETS, 4, number of coefficient sets stored in the ROM.
- COEFF_W, 16, signed coefficient width in the ROM.
- DATA_W, 32, hwdata width.
- ADDR_W, 32, haddr width.
- ROM_AW, 7, ROM address width; must satisfy 2^ROM_AW >= NUM_SETS*NUM_TAPS.

Ports:
- clk  in  1  system clock, all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start_i  in  1  one-cycle load request.
- set_sel_i  in  2  set index, sampled when start_i is accepted.
- busy_o  out  1  high from start acceptance until commit.
- commit_o  out  1  one-cycle pulse when the loaded set is committed by vs.
- err_o  out  1  one-cycle pulse when set_sel_i >= NUM_SETS.
- rom_en_o  out  1  ROM read enable.
- rom_addr_o  out  ROM_AW  ROM read address.
- rom_data_i  in  COEFF_W  ROM data, valid the cycle after rom_en_o.
- haddr  out  ADDR_W  coefficient index (address phase).
- hwdata  out  DATA_W  sign-extended coefficient (data phase).
- hwrite  out  1  address-phase write valid.
- hready  in  1  slave ready; when low, stalls both the address and data phases.
- vs_i  in  1  frame sync from the video timing.
- vs_o  out  1  gated frame sync, connected to bram2coeff vs_i.

Behaviour:
- Reset values: busy_o, commit_o, err_o, rom_en_o, hwrite are 0; haddr, hwdata, rom_addr_o are 0; the data-hold register is 0; FSM is in IDLE.
- Reset mid-operation aborts immediately; no further beats are issued.

FSM states: IDLE, XFER, LAST, WAIT_VS.
- IDLE:
  - start_i with a valid set: latch base = set_sel_i*NUM_TAPS, set idx=0, busy_o=1, go to XFER.
  - start_i with an invalid set: err_o pulses next cycle, stay in IDLE.
- XFER (address phase of idx):
  - Drive hwrite=1, haddr=idx, rom_en_o=1, rom_addr_o=base+idx.
  - The beat is accepted when hready=1. Then idx increments; after idx=NUM_TAPS-1 is accepted, go to LAST.
  - While hready=0: hold haddr, hwrite and rom_addr_o; rom_en_o=0.
- Data phase of beat k occurs in the cycle after its acceptance.
  - hwdata = sign_extend(rom_data_i) in the first data-phase cycle.
  - The value is captured into the hold register; while hready=0, hwdata is driven from the hold register.
  - Address k+1 and data k overlap in the same cycle.
- LAST: hwrite=0, rom_en_o=0, drives data for beat NUM_TAPS-1. When hready=1, go to WAIT_VS.
- WAIT_VS: on the first vs_i rising edge (vs_i=1, registered vs_q=0):
  - vs_o passes that edge through;
  - commit_o pulses in the next cycle; busy_o clears in the same cycle as commit_o; go to IDLE.
- vs gating: vs_o = vs_i & ~gate.
  - gate is registered; it sets on start acceptance and clears on entry to WAIT_VS.
  - A vs_i edge during XFER/LAST is therefore suppressed.
  - In IDLE and WAIT_VS, vs_o follows vs_i combinationally.
- start_i while busy_o=1 is ignored; no error is flagged.
- Nominal latency with hready held at 1:
  - start in cycle 0; haddr=0 in cycle 1; haddr=24 in cycle 25;
  - last data in cycle 26; WAIT_VS from cycle 27.
- hwdata changes only in data-phase cycles. Between loads it holds its last value; haddr holds its last value.

Decomposition:
- Shared package fir2d_pkg:
  - NUM_TAPS, NUM_SETS, COEFF_W;
  - FSM state encoding (IDLE=0, XFER=1, LAST=2, WAIT_VS=3);
  - a sign-extend helper function.
- No sub-module required.
- An optional sub-module coeff_load_rise_det (vs_i edge register) is permitted but not mandated.

Test Plan:
- Set 0, hready=1, ROM[k]=k+10: haddr 0..24 in cycles 1..25; hwdata 10..34 in cycles 2..26; vs_i pulse at cycle 40 → vs_o pulses, commit_o=1 at cycle 41.
- Set 2, ROM[50+k]=-k (0xFFFF..): hwdata=0xFFFFFFFF for k=1; rom_addr_o runs 50..74.
- hready low for 3 cycles at beat 7: haddr=7 and hwdata=coeff[6] are held for 3 cycles; total beats=25, no duplicates or skips.
- vs_i rising edge at cycle 10 (during XFER) → vs_o stays 0 and no commit; a later vs_i edge → commit_o.
- set_sel_i=3 with NUM_SETS=3 → err_o pulse, busy_o=0, hwrite never asserted; start_i at cycle 5 of a load → ignored.
- rst asserted at beat 12 → all outputs at reset values the next cycle; a new start then begins at haddr=0.
